// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared types and constants for the LED pattern sequencer.
//   - state_e      : controller states
//   - MODE_*       : encodings of the 2-bit mode input
//   - *_SEED/_ON   : entry patterns for the running states
//   - mode_to_state: maps a sampled mode code to the state it starts
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATIC,
    ST_BLINK,
    ST_CHASE,
    ST_BREATHE
  } state_e;

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_CHASE   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam logic [7:0] STATIC_ON  = 8'h01;
  localparam logic [7:0] CHASE_SEED = 8'h01;
  localparam logic [7:0] BLINK_ON   = 8'hFF;

  function automatic state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_STATIC:  return ST_STATIC;
      MODE_BLINK:   return ST_BLINK;
      MODE_CHASE:   return ST_CHASE;
      default:      return ST_BREATHE;
    endcase
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler
//   Free-running divider producing a one-cycle tick every CLK_DIV enabled
//   cycles. Generic so it can time other outputs later.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : count enable; count holds and no tick while low
//     clr        : synchronous clear to 0 (wins over en)
//     tick       : high while enabled and the count sits at CLK_DIV-1
module led_prescaler #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//   LED bank pattern controller: STATIC, BLINK, CHASE and PWM BREATHE
//   patterns, stepped by an internal prescaler tick, with a final polarity
//   XOR on the output pins.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     ena        : design enable; freezes prescaler, PWM counter and pattern
//     mode[1:0]  : pattern select, sampled only when leaving IDLE
//     run        : level; high starts/sustains a sequence, low returns to IDLE
//     invert     : output polarity; 1 inverts every LED bit
//     led[7:0]   : pattern ^ {8{invert}}
//     busy       : state is not IDLE
//     tick       : one-cycle pulse on each prescaler wrap
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] mode,
  input  logic       run,
  input  logic       invert,
  output logic [7:0] led,
  output logic       busy,
  output logic       tick
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  state_e              state_q, state_d;
  logic [7:0]          pattern_q, pattern_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                dir_down_q, dir_down_d;
  logic                presc_clr;
  logic                tick_w;

  assign busy = (state_q != ST_IDLE);
  assign tick = tick_w;
  assign led  = pattern_q ^ {8{invert}};

  led_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy && ena),
    .clr   (presc_clr),
    .tick  (tick_w)
  );

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q;
    dir_down_d = dir_down_q;
    presc_clr  = 1'b0;

    if (state_q == ST_IDLE) begin
      pattern_d = '0;
      if (run) begin
        // Leaving IDLE: latch mode once and load the entry pattern.
        presc_clr  = 1'b1;
        state_d    = mode_to_state(mode);
        duty_d     = '0;
        pwm_cnt_d  = '0;
        dir_down_d = 1'b0;
        case (mode)
          MODE_STATIC: pattern_d = STATIC_ON;
          MODE_BLINK:  pattern_d = BLINK_ON;
          MODE_CHASE:  pattern_d = CHASE_SEED;
          default:     pattern_d = '0;
        endcase
      end
    end else if (!run) begin
      // Stop wins over any tick in the same cycle.
      state_d   = ST_IDLE;
      pattern_d = '0;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_BLINK: begin
          if (tick_w) pattern_d = ~pattern_q;
        end
        ST_CHASE: begin
          if (tick_w) pattern_d = {pattern_q[6:0], pattern_q[7]};
        end
        ST_BREATHE: begin
          if (ena) pwm_cnt_d = pwm_cnt_q + ONE;
          if (tick_w) begin
            duty_d = dir_down_q ? duty_q - ONE : duty_q + ONE;
            // Turn around as the endpoint is reached so it is held one tick.
            if (duty_d == DUTY_MAX)  dir_down_d = 1'b1;
            else if (duty_d == '0)   dir_down_d = 1'b0;
          end
          // Built from next-state values so the registered pattern always
          // matches the registered counter and duty.
          pattern_d = {8{pwm_cnt_d < duty_d}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pattern_q  <= '0;
      duty_q     <= '0;
      pwm_cnt_q  <= '0;
      dir_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      dir_down_q <= dir_down_d;
    end
  end

endmodule
